// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI-lite responder backed by a word-addressed on-chip memory.
// Independent read and write channels, each sequenced by a small FSM that
// inserts a fixed or LFSR-derived response delay before answering. Accesses
// outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) complete with SLVERR and never
// touch memory.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_araddr/s_arvalid/s_arready   read address channel
//   s_rdata/s_rresp/s_rvalid/s_rready  read data channel
//   s_awaddr/s_awvalid/s_awready   write address channel
//   s_wdata/s_wstrb/s_wvalid/s_wready  write data channel
//   s_bresp/s_bvalid/s_bready      write response channel
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_DELAY   = 2,
  parameter int unsigned WR_DELAY   = 2,
  parameter bit          RAND_DELAY = 1'b0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = 8;
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + (33'(DEPTH) << 2);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  // Range check done in 33 bits so the upper bound cannot wrap.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= 33'(BASE_ADDR)) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] to_index(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [31:0] mem [DEPTH];

  r_state_e         r_state_q, r_state_d;
  w_state_e         w_state_q, w_state_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic [31:0]      araddr_q;
  logic [31:0]      awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [7:0]       lfsr_q, lfsr_d;

  logic             ar_hs, aw_hs, w_hs, b_hs, wr_go;
  logic             r_enter, w_enter, w_commit;
  logic [31:0]      rd_addr, wr_addr, wr_data;
  logic [3:0]       wr_strb;
  logic             rd_ok, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [7:0]       lfsr_nx, lfsr_wr;
  logic [CNT_W-1:0] rd_delay, wr_delay;

  // Handshakes; ready flags are registered, so these depend on inputs only
  // through valid/ready of the upstream side.
  assign ar_hs = s_arvalid & s_arready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  // A dropped ready means that half of the write is already captured.
  assign wr_go = (w_state_q == W_IDLE) & (aw_hs | ~s_awready) & (w_hs | ~s_wready);

  // With zero delay the response is produced on the capture edge, before the
  // holding registers are loaded, so the live bus values are used.
  assign rd_addr = (r_state_q == R_IDLE) ? s_araddr : araddr_q;
  assign wr_addr = s_awready ? s_awaddr : awaddr_q;
  assign wr_data = s_wready  ? s_wdata  : wdata_q;
  assign wr_strb = s_wready  ? s_wstrb  : wstrb_q;

  assign rd_ok  = in_range(rd_addr);
  assign wr_ok  = in_range(wr_addr);
  assign rd_idx = to_index(rd_addr);
  assign wr_idx = to_index(wr_addr);

  // When a read and a write start together, the read takes the current LFSR
  // value and the write the following one.
  assign lfsr_nx  = lfsr_step(lfsr_q);
  assign lfsr_wr  = ar_hs ? lfsr_nx : lfsr_q;
  assign rd_delay = RAND_DELAY ? CNT_W'(lfsr_q[2:0])  : CNT_W'(RD_DELAY);
  assign wr_delay = RAND_DELAY ? CNT_W'(lfsr_wr[2:0]) : CNT_W'(WR_DELAY);

  // LFSR advance: once per started transaction.
  always_comb begin
    lfsr_d = lfsr_q;
    if (ar_hs && wr_go) begin
      lfsr_d = lfsr_step(lfsr_nx);
    end else if (ar_hs || wr_go) begin
      lfsr_d = lfsr_nx;
    end
  end

  // Read FSM next state and delay counter.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (rd_delay == '0) begin
            r_state_d = R_RESP;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = rd_delay;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q <= CNT_W'(1)) begin
          r_state_d = R_RESP;
          r_cnt_d   = '0;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        r_cnt_d   = '0;
      end
    endcase
  end

  assign r_enter = (r_state_d == R_RESP) && (r_state_q != R_RESP);

  // Read channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      araddr_q  <= '0;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      s_arready <= (r_state_d == R_IDLE);
      s_rvalid  <= (r_state_d == R_RESP);
      if (ar_hs) begin
        araddr_q <= s_araddr;
      end
      if (r_enter) begin
        s_rdata <= rd_ok ? mem[rd_idx] : '0;
        s_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Write FSM next state and delay counter.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_go) begin
          if (wr_delay == '0) begin
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_WAIT;
            w_cnt_d   = wr_delay;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q <= CNT_W'(1)) begin
          w_state_d = W_RESP;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (s_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign w_enter  = (w_state_d == W_RESP) && (w_state_q != W_RESP);
  // Qualified by rst_n so nothing is written while reset is held.
  assign w_commit = rst_n & w_enter & wr_ok;

  // Write channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_awready <= 1'b1;
      s_wready  <= 1'b1;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      s_bvalid  <= (w_state_d == W_RESP);
      if (aw_hs) begin
        awaddr_q  <= s_awaddr;
        s_awready <= 1'b0;
      end else if (b_hs) begin
        s_awready <= 1'b1;
      end
      if (w_hs) begin
        wdata_q  <= s_wdata;
        wstrb_q  <= s_wstrb;
        s_wready <= 1'b0;
      end else if (b_hs) begin
        s_wready <= 1'b1;
      end
      if (w_enter) begin
        s_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Delay LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Storage array, byte-lane write; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb_axi_lite_sram: self-checking bench for axi_lite_sram.
// Three instances: u0 fixed delay 2/2, u1 fixed delay 0/0, u2 LFSR delays.
// Expected responses are queued when a transaction is issued and compared
// when the DUT answers.
module tb_axi_lite_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        rready, bready;

  logic        arvalid [3];
  logic        awvalid [3];
  logic        wvalid  [3];
  logic        arready [3];
  logic        awready [3];
  logic        wready  [3];
  logic        rvalid  [3];
  logic        bvalid  [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic [1:0]  bresp   [3];

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        rq[$];
  exp_t        bq[$];
  logic [31:0] model [3][1024];
  logic [7:0]  lfsr_m;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  axi_lite_sram #(.RD_DELAY(2), .WR_DELAY(2), .RAND_DELAY(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .s_araddr(araddr), .s_arvalid(arvalid[0]), .s_arready(arready[0]),
    .s_rdata(rdata[0]), .s_rresp(rresp[0]), .s_rvalid(rvalid[0]), .s_rready(rready),
    .s_awaddr(awaddr), .s_awvalid(awvalid[0]), .s_awready(awready[0]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid[0]), .s_wready(wready[0]),
    .s_bresp(bresp[0]), .s_bvalid(bvalid[0]), .s_bready(bready));

  axi_lite_sram #(.RD_DELAY(0), .WR_DELAY(0), .RAND_DELAY(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .s_araddr(araddr), .s_arvalid(arvalid[1]), .s_arready(arready[1]),
    .s_rdata(rdata[1]), .s_rresp(rresp[1]), .s_rvalid(rvalid[1]), .s_rready(rready),
    .s_awaddr(awaddr), .s_awvalid(awvalid[1]), .s_awready(awready[1]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid[1]), .s_wready(wready[1]),
    .s_bresp(bresp[1]), .s_bvalid(bvalid[1]), .s_bready(bready));

  axi_lite_sram #(.RAND_DELAY(1'b1), .LFSR_SEED(8'hA5)) u2 (
    .clk(clk), .rst_n(rst_n),
    .s_araddr(araddr), .s_arvalid(arvalid[2]), .s_arready(arready[2]),
    .s_rdata(rdata[2]), .s_rresp(rresp[2]), .s_rvalid(rvalid[2]), .s_rready(rready),
    .s_awaddr(awaddr), .s_awvalid(awvalid[2]), .s_awready(awready[2]),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid[2]), .s_wready(wready[2]),
    .s_bresp(bresp[2]), .s_bvalid(bvalid[2]), .s_bready(bready));

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a <= 32'h8000_0FFC);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - 32'h8000_0000) >> 2);
  endfunction

  // Delay the given instance will apply to its next transaction.
  function automatic int take_delay(input int u);
    int d;
    if (u == 2) begin
      d = int'(lfsr_m[2:0]);
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end else if (u == 1) begin
      d = 0;
    end else begin
      d = 2;
    end
    return d;
  endfunction

  task automatic do_read(input int u, input logic [31:0] addr);
    exp_t e, g;
    bit   hs;
    int   tries, lat;
    e.lat  = take_delay(u) + 1;
    e.data = in_rng(addr) ? model[u][idx(addr)] : 32'h0;
    e.resp = in_rng(addr) ? 2'b00 : 2'b10;
    rq.push_back(e);
    araddr = addr;
    arvalid[u] = 1'b1;
    hs = 1'b0;
    tries = 0;
    while (!hs && tries < 20) begin
      hs = arready[u];
      @(posedge clk); #1;
      tries++;
    end
    arvalid[u] = 1'b0;
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL ar_handshake u%0d: arready never seen, required 1", u); end
    n_checks++;
    if (arready[u] !== 1'b0) begin n_fail++; $display("FAIL arready_busy u%0d: got %b required 0", u, arready[u]); end
    lat = 1;
    while (rvalid[u] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    g = rq.pop_front();
    n_checks++;
    if (lat !== g.lat) begin n_fail++; $display("FAIL rd_latency u%0d addr %h: got %0d required %0d", u, addr, lat, g.lat); end
    n_checks++;
    if (rdata[u] !== g.data) begin n_fail++; $display("FAIL rdata u%0d addr %h: got %h required %h", u, addr, rdata[u], g.data); end
    n_checks++;
    if (rresp[u] !== g.resp) begin n_fail++; $display("FAIL rresp u%0d addr %h: got %b required %b", u, addr, rresp[u], g.resp); end
    @(posedge clk); #1;
    n_checks++;
    if (rvalid[u] !== 1'b0 || arready[u] !== 1'b1) begin
      n_fail++; $display("FAIL r_release u%0d: rvalid %b arready %b required 0 1", u, rvalid[u], arready[u]);
    end
  endtask

  // gap > 0 presents W that many cycles before AW; hold keeps bready low
  // for five cycles once bvalid rises.
  task automatic do_write(input int u, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int gap, input bit hold);
    exp_t e, g;
    bit   hs;
    int   tries, lat;
    e.data = 32'h0;
    e.resp = in_rng(addr) ? 2'b00 : 2'b10;
    if (in_rng(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[u][idx(addr)][8*b +: 8] = data[8*b +: 8];
      end
    end
    if (hold) bready = 1'b0;
    wdata = data;
    wstrb = strb;
    wvalid[u] = 1'b1;
    if (gap > 0) begin
      @(posedge clk); #1;
      wvalid[u] = 1'b0;
      n_checks++;
      if (wready[u] !== 1'b0) begin n_fail++; $display("FAIL wready_after_w u%0d: got %b required 0", u, wready[u]); end
      repeat (gap - 1) @(posedge clk);
      #1;
      n_checks++;
      if (wready[u] !== 1'b0 || bvalid[u] !== 1'b0) begin
        n_fail++; $display("FAIL w_waiting_aw u%0d: wready %b bvalid %b required 0 0", u, wready[u], bvalid[u]);
      end
    end
    e.lat = take_delay(u) + 1;
    bq.push_back(e);
    awaddr = addr;
    awvalid[u] = 1'b1;
    hs = 1'b0;
    tries = 0;
    while (!hs && tries < 20) begin
      hs = awready[u];
      @(posedge clk); #1;
      tries++;
    end
    awvalid[u] = 1'b0;
    wvalid[u] = 1'b0;
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL aw_handshake u%0d: awready never seen, required 1", u); end
    lat = 1;
    while (bvalid[u] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    g = bq.pop_front();
    n_checks++;
    if (lat !== g.lat) begin n_fail++; $display("FAIL wr_latency u%0d addr %h: got %0d required %0d", u, addr, lat, g.lat); end
    n_checks++;
    if (bresp[u] !== g.resp) begin n_fail++; $display("FAIL bresp u%0d addr %h: got %b required %b", u, addr, bresp[u], g.resp); end
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        n_checks++;
        if (bvalid[u] !== 1'b1 || bresp[u] !== g.resp) begin
          n_fail++; $display("FAIL b_hold u%0d cycle %0d: bvalid %b bresp %b required 1 %b", u, i, bvalid[u], bresp[u], g.resp);
        end
      end
      bready = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bvalid[u] !== 1'b0 || awready[u] !== 1'b1 || wready[u] !== 1'b1) begin
      n_fail++; $display("FAIL b_release u%0d: bvalid %b awready %b wready %b required 0 1 1", u, bvalid[u], awready[u], wready[u]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 3; u++) begin
      n_checks++;
      if (arready[u] !== 1'b1 || awready[u] !== 1'b1 || wready[u] !== 1'b1 ||
          rvalid[u] !== 1'b0 || bvalid[u] !== 1'b0 || rdata[u] !== 32'h0 ||
          rresp[u] !== 2'b00 || bresp[u] !== 2'b00) begin
        n_fail++;
        $display("FAIL %s u%0d: ar/aw/w ready %b%b%b rvalid %b bvalid %b rdata %h rresp %b bresp %b required 111 0 0 00000000 00 00",
                 tag, u, arready[u], awready[u], wready[u], rvalid[u], bvalid[u], rdata[u], rresp[u], bresp[u]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    lfsr_m = 8'hA5;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    do_read(0, 32'h8000_0010);
    do_read(0, 32'h8000_0010);
  endtask

  task automatic test_partial();
    do_write(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 1'b0);
    n_checks++;
    if (model[0][4] !== 32'hDE22_BE44) begin n_fail++; $display("FAIL partial_model: got %h required DE22BE44", model[0][4]); end
    do_read(0, 32'h8000_0010);
  endtask

  task automatic test_w_before_aw();
    do_write(0, 32'h8000_0020, 32'hA5A5_0F0F, 4'hF, 4, 1'b1);
    do_read(0, 32'h8000_0020);
  endtask

  task automatic test_out_of_range();
    do_write(0, 32'h8000_0000, 32'h0000_1111, 4'hF, 0, 1'b0);
    do_write(0, 32'h8000_0FFC, 32'hFFFF_2222, 4'hF, 0, 1'b0);
    do_read(0, 32'h7FFF_FFFC);
    do_read(0, 32'h8000_1000);
    do_write(0, 32'h7FFF_FFFC, 32'hBAD0_0001, 4'hF, 0, 1'b0);
    do_write(0, 32'h8000_1000, 32'hBAD0_0002, 4'hF, 0, 1'b0);
    do_read(0, 32'h8000_0000);
    do_read(0, 32'h8000_0FFC);
  endtask

  task automatic test_simultaneous();
    exp_t er, eb, g;
    logic [31:0] a;
    a = 32'h8000_0040;
    do_write(1, a, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
    er.lat = take_delay(1) + 1; er.data = model[1][idx(a)]; er.resp = 2'b00;
    rq.push_back(er);
    eb.lat = take_delay(1) + 1; eb.data = 32'h0; eb.resp = 2'b00;
    bq.push_back(eb);
    model[1][idx(a)] = 32'h600D_CAFE;
    araddr = a; awaddr = a; wdata = 32'h600D_CAFE; wstrb = 4'hF;
    arvalid[1] = 1'b1; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    @(posedge clk); #1;
    arvalid[1] = 1'b0; awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    g = rq.pop_front();
    n_checks++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== g.data) begin
      n_fail++; $display("FAIL simul_read: rvalid %b rdata %h required 1 %h", rvalid[1], rdata[1], g.data);
    end
    g = bq.pop_front();
    n_checks++;
    if (bvalid[1] !== 1'b1 || bresp[1] !== g.resp) begin
      n_fail++; $display("FAIL simul_write: bvalid %b bresp %b required 1 %b", bvalid[1], bresp[1], g.resp);
    end
    @(posedge clk); #1;
    do_read(1, a);
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a;
    a = 32'h8000_0014;
    do_write(0, a, 32'hCAFE_0001, 4'hF, 0, 1'b0);
    do_read(0, a);
    araddr = a; awaddr = a; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    arvalid[0] = 1'b1; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    @(posedge clk); #1;
    arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    n_checks++;
    if (rvalid[0] !== 1'b0 || bvalid[0] !== 1'b0 || arready[0] !== 1'b0 || awready[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_wait: rvalid %b bvalid %b arready %b awready %b required 0 0 0 0",
                         rvalid[0], bvalid[0], arready[0], awready[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_wait");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    lfsr_m = 8'hA5;
    @(posedge clk); #1;
    do_read(0, a);
  endtask

  task automatic test_rand_delay();
    do_write(2, 32'h8000_0100, 32'h1357_9BDF, 4'hF, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_read(2, (i % 5 == 4) ? 32'h9000_0000 : 32'h8000_0100);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    rready = 1'b1; bready = 1'b1;
    lfsr_m = 8'hA5;
    for (int u = 0; u < 3; u++) begin
      arvalid[u] = 1'b0; awvalid[u] = 1'b0; wvalid[u] = 1'b0;
    end
    test_reset();
    test_basic();
    test_partial();
    test_w_before_aw();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid_wait();
    test_rand_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
